instr_fetch: RTL and testbench
==============================

# instr_fetch

Fetch/load front end for the instruction memory. It accepts a program as a word stream and writes it into instruction memory. On `start` it walks the program counter, reads one 26-bit opcode per instruction and presents it to the execution engine over a valid/ready handshake. It sits between the program source and the instruction memory, and between the instruction memory and the execution engine.

## Interface
Parameters:
- `DEPTH`, default 10: instruction memory entries.
- `AW`, default 4: pointer width.
- `OW`, default 26: opcode width.

Ports:
- `clk` in 1: system clock; all state changes on posedge.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `load_valid` in 1: program word offered.
- `load_data` in OW: program word.
- `load_last` in 1: qualifies the final word of the program.
- `load_ready` out 1: loader can accept a word.
- `start` in 1: begin execution at pc 0.
- `mem_prog_pointer` out AW: instruction memory address.
- `mem_write_data` out 1: instruction memory write enable.
- `mem_data_to_write` out OW: instruction memory write data.
- `mem_opcode` in OW: instruction memory read data, valid the cycle after the address is presented with write low.
- `instr_valid` out 1: instruction available to the execution engine.
- `instr` out OW: instruction to the execution engine.
- `instr_ready` in 1: execution engine accepts the instruction.
- `jump_valid` in 1: redirect; sampled only on the issue handshake.
- `jump_target` in AW: next pc when `jump_valid`.
- `pc` out AW: current program counter.
- `prog_len` out AW: number of loaded words.
- `halted` out 1: execution stopped.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, LOAD, FETCH, CAPT, ISSUE, HALT.
- **IDLE**
  - `load_ready`=1.
  - A word accept (`load_valid`&&`load_ready`) clears `prog_len` and the write pointer, writes entry 0, and moves to LOAD. If `load_last` is set on that first word, it returns straight to IDLE.
  - `start` with `prog_len`>0: pc←0, go to FETCH. With `prog_len`==0: set `err`, stay in IDLE.
  - A word accept has priority over `start` in the same cycle.
- **LOAD**
  - `load_ready`=1.
  - Each accept writes the word at the write pointer and increments the pointer and `prog_len`.
  - The accept carrying `load_last` returns to IDLE.
  - An accept with the write pointer ==DEPTH drops the word and sets `err`. `load_last` still terminates the load.
  - `start` is ignored.
- **FETCH**: drive `mem_prog_pointer`=pc with `mem_write_data`=0 for one cycle, then go to CAPT.
- **CAPT**
  - If `mem_opcode[OW-1:OW-4]` == `OPC_HALT` (4'hF): go to HALT; the instruction is not issued.
  - Otherwise `instr`←`mem_opcode`, `instr_valid`←1, go to ISSUE.
- **ISSUE**
  - Hold `instr` and `instr_valid` until `instr_ready`.
  - On the handshake:
    - `jump_valid`: next pc = `jump_target`.
    - Otherwise: next pc = pc+1.
  - If next pc ≥ `prog_len`: go to HALT. This is the normal end of program, except an out-of-range jump also sets `err`.
  - Otherwise go to FETCH with pc←next pc.
- **HALT**
  - `halted`=1.
  - `start` restarts at pc 0 (FETCH).
  - A word accept starts a new load (as in IDLE).
- **Reset**
  - Returns to IDLE and clears every output: `load_ready` 0 in the reset cycle, then 1 in IDLE.
  - `pc`, `prog_len`, `err`, `instr`, `instr_valid`, `halted` and all `mem_*` are 0.
  - Mid-load or mid-execution, reset aborts with no further memory writes. Memory contents are not cleared by this block.
- **Arithmetic**: pc+1 is computed at AW+1 bits before comparison, so no wrap aliasing.

## Timing
- All outputs are registered.
- A word accepted in cycle N produces `mem_write_data`=1 with its address/data in cycle N+1 only.
- `start` accepted in cycle S:
  - S+1: FETCH, `mem_prog_pointer`=0.
  - S+2: CAPT.
  - S+3: `instr_valid`=1.
- Handshake in cycle H: `instr_valid`=0 in H+1, next instruction valid at H+3. Peak rate is one instruction per 3 cycles.
- HALT detected in CAPT at cycle C gives `halted`=1 at C+1.
- `start` in the cycle after the `load_last` accept is legal: the final write lands in that cycle and the first read follows.
- `err` stays set until reset.

## Structure
- Shared package holds:
  - The state enum.
  - `OPC_HALT`=4'hF.
  - The halt field position (opcode bits [25:22]).
  - `DEPTH`/`AW`/`OW` defaults, reused by the execution engine and instruction memory.
- No sub-module: a single FSM plus pc, write-pointer and length counters.

## Test plan
- **Load then run**: load 3 words (0x0000001, 0x0000002, 0x0000003, last on the third), start → `instr` 1, 2, 3 at S+3, H+3, H+3; then `halted`=1, `err`=0.
- **Backpressure**: hold `instr_ready`=0 for 5 cycles in ISSUE → `instr` stable and `instr_valid` held; the pointer does not advance.
- **Halt opcode**: program {0x0000001, 0x3C00000, 0x0000005}, start → only 0x0000001 is issued; `halted` follows the second read; 0x0000005 is never presented.
- **Jump**: 4-word program, `jump_valid` with target 0 on the third handshake → issue order 0, 1, 2, 0, 1, …; target 9 with `prog_len`=4 → HALT with `err`=1.
- **Overflow and empty start**:
  - 11-word load → 10 memory writes, `prog_len`=10, `err`=1.
  - After reset, start with no load → stays IDLE, `err`=1.
- **Reset mid-operation**: assert reset during ISSUE and during LOAD → next cycle all outputs 0, no `mem_write_data` pulse, state IDLE.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch front end, the execution
// engine and the instruction memory: default sizes, the halt opcode field
// and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int DEPTH_DEF = 10;
  localparam int AW_DEF    = 4;
  localparam int OW_DEF    = 26;

  // Halt is recognised from the top nibble of the opcode word.
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam int         HALT_MSB = 25;
  localparam int         HALT_LSB = 22;
  localparam int         HALT_W   = HALT_MSB - HALT_LSB + 1;

  // Fetch FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_CAPT  = 3'd3;
  localparam state_t ST_ISSUE = 3'd4;
  localparam state_t ST_HALT  = 3'd5;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch front end and its neighbours: program
// loader, instruction memory and execution engine. The master side is the
// fetch unit; the slave side is everything around it.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int OW = OW_DEF
);
  logic          load_valid;
  logic [OW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          start;
  logic [AW-1:0] mem_prog_pointer;
  logic          mem_write_data;
  logic [OW-1:0] mem_data_to_write;
  logic [OW-1:0] mem_opcode;
  logic          instr_valid;
  logic [OW-1:0] instr;
  logic          instr_ready;
  logic          jump_valid;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] pc;
  logic [AW-1:0] prog_len;
  logic          halted;
  logic          err;

  modport master (
    input  load_valid, load_data, load_last, start, mem_opcode,
           instr_ready, jump_valid, jump_target,
    output load_ready, mem_prog_pointer, mem_write_data, mem_data_to_write,
           instr_valid, instr, pc, prog_len, halted, err
  );

  modport slave (
    output load_valid, load_data, load_last, start, mem_opcode,
           instr_ready, jump_valid, jump_target,
    input  load_ready, mem_prog_pointer, mem_write_data, mem_data_to_write,
           instr_valid, instr, pc, prog_len, halted, err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: loads a program word stream into the
// instruction memory, then walks the program counter, reading one opcode
// per instruction and handing it to the execution engine over valid/ready.
// Every output is a register.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int OW    = OW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LEN_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW:0]   wptr;
  logic [AW-1:0] pc;
  logic [AW-1:0] prog_len;
  logic [AW-1:0] mem_prog_pointer;
  logic          mem_write_data;
  logic [OW-1:0] mem_data_to_write;
  logic          load_ready;
  logic          instr_valid;
  logic [OW-1:0] instr;
  logic          halted;
  logic          err;

  logic          accept;
  logic [AW:0]   pc_next;
  logic          pc_end;

  assign accept = bus.load_valid && load_ready;

  // Next pc on an issue handshake, one bit wider so pc+1 never wraps onto a
  // valid address before the length compare.
  always_comb begin
    pc_next = bus.jump_valid ? {1'b0, bus.jump_target} : ({1'b0, pc} + PTR_ONE);
    pc_end  = (pc_next >= {1'b0, prog_len});
  end

  // Loader / fetch FSM with its pc, write-pointer and length counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      wptr              <= '0;
      pc                <= '0;
      prog_len          <= '0;
      mem_prog_pointer  <= '0;
      mem_write_data    <= 1'b0;
      mem_data_to_write <= '0;
      load_ready        <= 1'b0;
      instr_valid       <= 1'b0;
      instr             <= '0;
      halted            <= 1'b0;
      err               <= 1'b0;
    end else begin
      mem_write_data <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          load_ready <= 1'b1;
          if (accept) begin
            // A new program always starts over at entry 0.
            mem_write_data    <= 1'b1;
            mem_prog_pointer  <= '0;
            mem_data_to_write <= bus.load_data;
            wptr              <= PTR_ONE;
            prog_len          <= LEN_ONE;
            halted            <= 1'b0;
            state             <= bus.load_last ? ST_IDLE : ST_LOAD;
          end else if (bus.start) begin
            if (prog_len != '0) begin
              pc               <= '0;
              mem_prog_pointer <= '0;
              halted           <= 1'b0;
              load_ready       <= 1'b0;
              state            <= ST_FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          load_ready <= 1'b1;
          if (accept) begin
            if (wptr >= DEPTH_W) begin
              err <= 1'b1;
            end else begin
              mem_write_data    <= 1'b1;
              mem_prog_pointer  <= wptr[AW-1:0];
              mem_data_to_write <= bus.load_data;
              wptr              <= wptr + PTR_ONE;
              prog_len          <= prog_len + LEN_ONE;
            end
            if (bus.load_last) state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          // Read address was set on entry; the opcode returns next cycle.
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          if (bus.mem_opcode[OW-1 -: HALT_W] == OPC_HALT) begin
            halted     <= 1'b1;
            load_ready <= 1'b1;
            state      <= ST_HALT;
          end else begin
            instr       <= bus.mem_opcode;
            instr_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.instr_ready) begin
            instr_valid <= 1'b0;
            if (pc_end) begin
              halted     <= 1'b1;
              load_ready <= 1'b1;
              if (bus.jump_valid) err <= 1'b1;
              state      <= ST_HALT;
            end else begin
              pc               <= pc_next[AW-1:0];
              mem_prog_pointer <= pc_next[AW-1:0];
              state            <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready        = load_ready;
  assign bus.mem_prog_pointer  = mem_prog_pointer;
  assign bus.mem_write_data    = mem_write_data;
  assign bus.mem_data_to_write = mem_data_to_write;
  assign bus.instr_valid       = instr_valid;
  assign bus.instr             = instr;
  assign bus.pc                = pc;
  assign bus.prog_len          = prog_len;
  assign bus.halted            = halted;
  assign bus.err               = err;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed load/run scenarios against a program-level
// model of the expected memory writes and issued instruction stream.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int AW    = 4;
  localparam int OW    = 26;
  localparam int DEPTH = 10;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  instr_fetch_if #(.AW(AW), .OW(OW)) bus ();
  instr_fetch #(.DEPTH(DEPTH), .AW(AW), .OW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: write on the enable, registered read.
  logic [OW-1:0] imem [0:15];
  always @(posedge clk) begin
    if (bus.mem_write_data) imem[bus.mem_prog_pointer] <= bus.mem_data_to_write;
    bus.mem_opcode <= imem[bus.mem_prog_pointer];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Program-level model.
  logic [OW-1:0]    prog      [0:15];
  logic [OW-1:0]    model_mem [0:15];
  int               model_len;
  logic [OW-1:0]    exp_q [$];
  logic [AW+OW-1:0] wexp_q [$];
  logic             exp_err;
  logic             halt_by_op;
  int               wr_count = 0;

  // Walk the loaded program the way the execution semantics describe it.
  task automatic model_run(input int jump_at, input int jump_tgt);
    int p, k, nxt;
    p = 0; k = 0;
    exp_q.delete();
    exp_err = 1'b0;
    halt_by_op = 1'b0;
    for (int g = 0; g < 64; g++) begin
      if (model_mem[p][OW-1 -: 4] == OPC_HALT) begin halt_by_op = 1'b1; break; end
      exp_q.push_back(model_mem[p]);
      nxt = (k == jump_at) ? jump_tgt : p + 1;
      if (nxt >= model_len) begin exp_err = (k == jump_at); break; end
      k++;
      p = nxt;
    end
  endtask

  // Compare process: memory writes, issued instructions, held outputs.
  logic             mon_hs;
  logic [AW+OW-1:0] mon_w;
  logic             prev_valid = 1'b0;
  logic             prev_hs = 1'b0;
  logic             prev_rst = 1'b1;
  logic [OW-1:0]    prev_instr = '0;
  always @(negedge clk) begin
    #1;
    if (bus.mem_write_data) begin
      wr_count++;
      if (wexp_q.size() == 0) chk("wr_unexpected", 32'(bus.mem_write_data), 32'd0);
      else begin
        mon_w = wexp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_prog_pointer), 32'(mon_w[AW+OW-1:OW]));
        chk("wr_data", 32'(bus.mem_data_to_write), 32'(mon_w[OW-1:0]));
      end
    end
    if (!prev_rst && prev_valid && !prev_hs) begin
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_instr", 32'(bus.instr), 32'(prev_instr));
    end
    mon_hs = bus.instr_valid && bus.instr_ready;
    if (mon_hs) begin
      if (exp_q.size() == 0) chk("instr_extra", 32'(bus.instr_valid), 32'd0);
      else chk("instr", 32'(bus.instr), 32'(exp_q.pop_front()));
    end
    prev_valid = bus.instr_valid;
    prev_hs    = mon_hs;
    prev_instr = bus.instr;
    prev_rst   = reset;
  end

  task automatic idle_inputs();
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_last   = 1'b0;
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_valid  = 1'b0;
    bus.jump_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_load_ready",  32'(bus.load_ready), 32'd0);
    chk("rst_mem_ptr",     32'(bus.mem_prog_pointer), 32'd0);
    chk("rst_mem_we",      32'(bus.mem_write_data), 32'd0);
    chk("rst_mem_wdata",   32'(bus.mem_data_to_write), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr",       32'(bus.instr), 32'd0);
    chk("rst_pc",          32'(bus.pc), 32'd0);
    chk("rst_prog_len",    32'(bus.prog_len), 32'd0);
    chk("rst_halted",      32'(bus.halted), 32'd0);
    chk("rst_err",         32'(bus.err), 32'd0);
    reset = 1'b0;
    idle_inputs();
    exp_q.delete();
    @(negedge clk);
    chk("idle_load_ready", 32'(bus.load_ready), 32'd1);
    chk("idle_mem_we",     32'(bus.mem_write_data), 32'd0);
  endtask

  // Offer prog[0..n-1]; returns at the negedge right after the last accept.
  task automatic load(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i < DEPTH) begin
        model_mem[i] = prog[i];
        wexp_q.push_back({AW'(i), prog[i]});
      end
    end
    model_len = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t = 0;
      while (!bus.load_ready && t < 10) begin @(negedge clk); t++; end
      if (t >= 10) chk("load_ready_timeout", 32'(bus.load_ready), 32'd1);
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_last  = (i == n - 1);
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = '0;
    chk("prog_len", 32'(bus.prog_len), 32'(model_len));
    chk("load_done_ready", 32'(bus.load_ready), 32'd1);
  endtask

  // Start at the current negedge and drive the engine side until halted.
  task automatic run(input int jump_at, input int jump_tgt,
                     input int stall_at, input int stall_len);
    int hs, stalls, ev, t;
    logic pv;
    logic [AW-1:0] pc_hold, ptr_hold;
    hs = 0; stalls = 0; pv = 1'b0;
    pc_hold = '0; ptr_hold = '0;
    model_run(jump_at, jump_tgt);
    bus.start = 1'b1;
    ev = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("fetch_ptr", 32'(bus.mem_prog_pointer), 32'd0);
    chk("fetch_we",  32'(bus.mem_write_data), 32'd0);
    for (t = 0; t < 300; t++) begin
      if (bus.halted) begin
        chk("halt_latency", 32'(cyc - ev), halt_by_op ? 32'd2 : 32'd0);
        break;
      end
      if (bus.instr_valid && !pv) chk("issue_latency", 32'(cyc - ev), 32'd2);
      pv = bus.instr_valid;
      if (bus.instr_valid) begin
        if (hs == stall_at && stalls < stall_len) begin
          if (stalls == 0) begin
            pc_hold  = bus.pc;
            ptr_hold = bus.mem_prog_pointer;
          end else begin
            chk("stall_pc",  32'(bus.pc), 32'(pc_hold));
            chk("stall_ptr", 32'(bus.mem_prog_pointer), 32'(ptr_hold));
          end
          stalls++;
          bus.instr_ready = 1'b0;
          bus.jump_valid  = 1'b1;
          bus.jump_target = '0;
        end else begin
          bus.instr_ready = 1'b1;
          bus.jump_valid  = (hs == jump_at);
          bus.jump_target = AW'(jump_tgt);
          hs++;
          ev = cyc + 1;
        end
      end else begin
        bus.instr_ready = 1'b0;
        bus.jump_valid  = 1'b0;
      end
      @(negedge clk);
    end
    if (t >= 300) chk("run_timeout", 32'(bus.halted), 32'd1);
    bus.instr_ready = 1'b0;
    bus.jump_valid  = 1'b0;
    chk("halted",     32'(bus.halted), 32'd1);
    chk("err",        32'(bus.err), 32'(exp_err));
    chk("issued_all", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin imem[i] = '0; model_mem[i] = '0; prog[i] = '0; end
    model_len = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Start with nothing loaded.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("empty_err",        32'(bus.err), 32'd1);
    chk("empty_load_ready", 32'(bus.load_ready), 32'd1);
    chk("empty_halted",     32'(bus.halted), 32'd0);
    repeat (3) @(negedge clk);
    chk("empty_no_issue",   32'(bus.instr_valid), 32'd0);
    do_reset();

    // Three-word program, started the cycle after the last word.
    prog[0] = 26'h0000001; prog[1] = 26'h0000002; prog[2] = 26'h0000003;
    load(3);
    chk("load3_err", 32'(bus.err), 32'd0);
    model_run(-1, 0);
    chk("model3_len",  32'(exp_q.size()), 32'd3);
    chk("model3_last", 32'(exp_q[2]), 32'h3);
    run(-1, 0, -1, 0);
    // Restart from HALT with backpressure on the second instruction.
    run(-1, 0, 1, 5);

    // Halt opcode in the middle of the program, loaded from HALT.
    prog[0] = 26'h0000001; prog[1] = 26'h3C00000; prog[2] = 26'h0000005;
    load(3);
    model_run(-1, 0);
    chk("model_halt_len", 32'(exp_q.size()), 32'd1);
    chk("model_halt_op",  32'(halt_by_op), 32'd1);
    run(-1, 0, -1, 0);

    // Jump back to 0 on the third handshake, then an out-of-range jump.
    prog[0] = 26'h0000010; prog[1] = 26'h0000011; prog[2] = 26'h0000012; prog[3] = 26'h0000013;
    load(4);
    model_run(2, 0);
    chk("model_jump_len", 32'(exp_q.size()), 32'd7);
    chk("model_jump_e3",  32'(exp_q[3]), 32'h10);
    run(2, 0, -1, 0);
    model_run(1, 9);
    chk("model_oor_err", 32'(exp_err), 32'd1);
    run(1, 9, -1, 0);
    do_reset();

    // Eleven words into a ten-entry memory.
    for (int i = 0; i < 11; i++) prog[i] = OW'(32'h100 + i);
    wr_count = 0;
    load(11);
    @(negedge clk);
    #2;
    chk("ovf_writes", 32'(wr_count), 32'd10);
    chk("ovf_err",    32'(bus.err), 32'd1);
    do_reset();

    // Reset in the middle of a load: only the two accepted words land.
    wexp_q.push_back({AW'(0), 26'h00000AA});
    wexp_q.push_back({AW'(1), 26'h00000BB});
    @(negedge clk);
    bus.load_valid = 1'b1; bus.load_data = 26'h00000AA;
    @(negedge clk);
    bus.load_data = 26'h00000BB;
    do_reset();
    repeat (3) @(negedge clk);
    chk("midload_wq", 32'(wexp_q.size()), 32'd0);

    // Reset while an instruction waits in ISSUE.
    prog[0] = 26'h0000007; prog[1] = 26'h0000008;
    load(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 10 && !bus.instr_valid; t++) @(negedge clk);
    chk("midissue_valid", 32'(bus.instr_valid), 32'd1);
    repeat (2) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 32'(bus.instr_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
